// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, op encodings and FSM states for the multiply/divide unit
package mdu_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    // Bit 0 of the op selects signed arithmetic, bit 1 selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - combinational conditional two's-complement negate
//
// Ports:
//   val_i  input  [W-1:0]  value to pass through or negate
//   neg_i  input           1 = output the two's complement of val_i
//   val_o  output [W-1:0]  result
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with Hi/Lo result registers
//
// Ports:
//   clk     input          clock, rising edge
//   rst_n   input          asynchronous active-low reset
//   Start   input          request an operation (accepted only when idle)
//   Op      input  [1:0]   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   RsData  input  [W-1:0] multiplicand / dividend
//   RtData  input  [W-1:0] multiplier / divisor
//   Busy    output         operation in progress
//   Done    output         one-cycle pulse when Hi/Lo are updated
//   Hi      output [W-1:0] product high word or remainder
//   Lo      output [W-1:0] product low word or quotient
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    import mdu_pkg::*;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      acc_q;     // shared working register: {upper, lower}
    logic [31:0]      b_q;       // multiplicand (mul) or divisor (div) magnitude
    logic             div_q;
    logic             neg_q;     // negate product / quotient
    logic             rneg_q;    // negate remainder (dividend sign)
    logic [31:0]      hi_q, lo_q;
    logic             done_q;

    // ------------------------------------------------------------------
    // Operand magnitudes, computed from the live inputs at the accept edge
    // ------------------------------------------------------------------
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign a_neg = op_is_signed(Op) & RsData[31];
    assign b_neg = op_is_signed(Op) & RtData[31];

    mdu_signfix #(.W(32)) u_fix_a (.val_i(RsData), .neg_i(a_neg), .val_o(a_mag));
    mdu_signfix #(.W(32)) u_fix_b (.val_i(RtData), .neg_i(b_neg), .val_o(b_mag));

    // ------------------------------------------------------------------
    // One iteration of each algorithm on the shared register
    // ------------------------------------------------------------------
    // Multiply: lower half holds the multiplier and is consumed LSB first;
    // the carry out of the add is shifted back into bit 63.
    logic [32:0] madd;
    logic [63:0] mul_next;

    assign madd     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {madd, acc_q[31:1]};

    // Divide: partial remainder shifted left by one, trial-subtract the
    // divisor, keep the difference and set a quotient bit when it fits.
    // A zero divisor always fits, which yields quotient all-ones and
    // remainder equal to the dividend with no special casing.
    logic [32:0] dtrial;
    logic [63:0] div_next;

    assign dtrial   = acc_q[63:31] - {1'b0, b_q};
    assign div_next = dtrial[32] ? {acc_q[62:0], 1'b0}
                                 : {dtrial[31:0], acc_q[30:0], 1'b1};

    // ------------------------------------------------------------------
    // Result sign fix
    // ------------------------------------------------------------------
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    mdu_signfix #(.W(64)) u_fix_prod (.val_i(acc_q),        .neg_i(neg_q),  .val_o(prod_fix));
    mdu_signfix #(.W(32)) u_fix_quo  (.val_i(acc_q[31:0]),  .neg_i(neg_q),  .val_o(quo_fix));
    mdu_signfix #(.W(32)) u_fix_rem  (.val_i(acc_q[63:32]), .neg_i(rneg_q), .val_o(rem_fix));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_CALC;
            ST_CALC: if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        Busy = 1'b0;
        if (state_q != ST_IDLE) Busy = 1'b1;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        cnt_q  <= '0;
                        div_q  <= op_is_div(Op);
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        if (op_is_div(Op)) begin
                            acc_q <= {32'd0, a_mag};
                            b_q   <= b_mag;
                        end else begin
                            acc_q <= {32'd0, b_mag};
                            b_q   <= a_mag;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_FIX: begin
                    if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request a new operation; sampled on the rising edge.
REQ-005 Op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 RsData  input  32  operand A (multiplicand or dividend), taken from the register-file read port.
REQ-007 RtData  input  32  operand B (multiplier or divisor), taken from the register-file read port.
REQ-008 Busy  output  1  high while an operation is in progress.
REQ-009 Done  output  1  one-cycle pulse; Hi/Lo hold the new result.
REQ-010 Hi  output  32  product[63:32] or remainder.
REQ-011 Lo  output  32  product[31:0] or quotient.

Function
REQ-012 The unit SHALL be an FSM with states IDLE, CALC and FIX; Busy SHALL be high exactly when the state is not IDLE.
REQ-013 Start SHALL be accepted only in IDLE; at the accept edge (E0) the unit SHALL latch Op, RsData and RtData, clear a 5-bit iteration counter and enter CALC.
REQ-014 A Start received in CALC or FIX SHALL be ignored, with no queuing.
REQ-015 For signed ops, the unit SHALL convert operands to magnitudes at E0 and record the result signs.
REQ-016 CALC SHALL perform one iteration per edge, E1..E32: shift-add for multiply, restore-subtract for divide, using a 64-bit working register.
REQ-017 At E32 (counter wraps 31->0) the FSM SHALL go to FIX.
REQ-018 At E33 the unit SHALL apply the sign fix, write Hi/Lo, set Done=1 and return to IDLE; Done SHALL be low again after E34.
REQ-019 Fixed latency: Done SHALL be high in the cycle after E33 for every op and every operand value.
REQ-020 A new Start at E34 SHALL be accepted, giving back-to-back issue every 34 cycles.
REQ-021 Signed multiply: the product SHALL be negated iff the operand signs differ; the result is the exact 64-bit two's-complement value.
REQ-022 Signed divide: the quotient SHALL be negated iff the signs differ; the remainder SHALL take the dividend's sign; the quotient truncates toward zero.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0, with no flag.
REQ-024 Divide by zero SHALL give Lo=0xFFFFFFFF and Hi=dividend (signed DIV: Lo=1 if the dividend is negative, else 0xFFFFFFFF); latency SHALL be unchanged.
REQ-025 Hi/Lo SHALL change only at a FIX edge and otherwise hold their value indefinitely.
REQ-026 Operand inputs changing after E0 SHALL have no effect on the result.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, counter=0, Busy=0, Done=0, Hi=0, Lo=0 and working register=0.
REQ-028 Reset asserted mid-operation SHALL abort it: no Done pulse and Hi/Lo=0.
REQ-029 Start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package mdu_pkg SHALL hold the Op encodings, the state enum (IDLE/CALC/FIX), WIDTH and ITER_COUNT=32.
REQ-031 One sub-module, mdu_signfix, SHALL be used: a combinational conditional two's-complement negate, instantiated for the operands and for the results.
REQ-032 The unit SHALL use a single shared 64-bit datapath for multiply and divide, with no combinational multiplier or divider.
REQ-033 The RTL SHALL be 120-400 lines.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, Done one cycle after E33.
REQ-035 MULT 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
REQ-036 DIV -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); then DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
REQ-037 DIVU 100 / 0 -> Lo=0xFFFFFFFF, Hi=100, same latency as a normal divide.
REQ-038 DIVU 100 / 7, with Start re-pulsed at E5 and RsData changed at E1 -> second Start ignored, Lo=14, Hi=2, exactly one Done.
REQ-039 rst_n pulsed low at E10 of a MULTU 5x6 -> no Done, Hi=Lo=0, Busy=0; Start after release gives Lo=30.
